// File: rtl/noise_env_mixer.sv
// noise_env_mixer
//   Downstream stage for the four LFSR noise voices. Each voice gets an
//   attack/sustain/release amplitude envelope driven by its switch gate. The
//   gated amplitudes are summed into a 10-bit mix level, which drives a
//   single-pin, frame-aligned PWM audio output.
//
// Parameters
//   NVOICE    number of voices (fixed at 4; the 10-bit mix is sized for 4)
//   RATE_DIV  clk cycles per envelope tick (>= 1)
//   ATK_STEP  amplitude increment per tick while attacking
//   REL_STEP  amplitude decrement per tick while releasing (linear mode)
//
// Build option
//   NOISE_MIX_EXP_RELEASE_EN  when defined, release decrements by
//                             max(amp>>3, 1) per tick (exponential decay)
//                             instead of REL_STEP.
//
// Ports
//   clk         system clock
//   reset       asynchronous, active-high reset
//   gate        per-voice enable from switches (asynchronous to clk)
//   voice_in    per-voice noise bit (clk domain)
//   pwm_out     PWM audio pin, duty = latched level / 1024
//   level       registered mix sum (0..1020)
//   env_active  per-voice flag, 1 while the envelope is not idle
module noise_env_mixer #(
  parameter int NVOICE   = 4,
  parameter int RATE_DIV = 50000,
  parameter int ATK_STEP = 8,
  parameter int REL_STEP = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NVOICE-1:0] gate,
  input  logic [NVOICE-1:0] voice_in,
  output logic              pwm_out,
  output logic [9:0]        level,
  output logic [NVOICE-1:0] env_active
);

  typedef enum logic [1:0] {
    IDLE,
    ATTACK,
    SUSTAIN,
    RELEASE
  } env_state_e;

  // A 1-bit prescaler is kept for RATE_DIV == 1; it simply stays at 0.
  localparam int            PW         = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(RATE_DIV - 1);

  // ---------------------------------------------------------------------------
  // Gate synchroniser (two flops)
  // ---------------------------------------------------------------------------
  logic [NVOICE-1:0] gate_m;
  logic [NVOICE-1:0] gate_s;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gate_m <= '0;
      gate_s <= '0;
    end else begin
      gate_m <= gate;
      gate_s <= gate_m;
    end
  end

  // ---------------------------------------------------------------------------
  // Envelope tick prescaler
  // ---------------------------------------------------------------------------
  logic [PW-1:0] presc;
  logic          tick;

  assign tick = (presc == PRESC_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Envelope step arithmetic
  // ---------------------------------------------------------------------------
  // Saturating add: computed wide enough that amp + ATK_STEP never wraps.
  function automatic logic [7:0] attack_step(input logic [7:0] a);
    logic [9:0] s;
    s = {2'b00, a} + 10'(ATK_STEP);
    return (s >= 10'd255) ? 8'd255 : s[7:0];
  endfunction

  // Floor-at-zero subtract.
  function automatic logic [7:0] release_step(input logic [7:0] a);
    logic [8:0] dec;
`ifdef NOISE_MIX_EXP_RELEASE_EN
    dec = {4'b0000, a[7:3]};
    if (dec == '0) begin
      dec = 9'd1;
    end
`else
    dec = 9'(REL_STEP);
`endif
    return ({1'b0, a} > dec) ? (a - dec[7:0]) : 8'd0;
  endfunction

  // ---------------------------------------------------------------------------
  // Per-voice envelope FSM: state register / next-state / outputs
  // ---------------------------------------------------------------------------
  env_state_e state   [NVOICE];
  env_state_e state_n [NVOICE];
  logic [7:0] amp     [NVOICE];
  logic [7:0] amp_n   [NVOICE];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NVOICE; i++) begin
        state[i] <= IDLE;
        amp[i]   <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NVOICE; i++) begin
        state[i] <= state_n[i];
        amp[i]   <= amp_n[i];
      end
    end
  end

  // A gate-driven transition takes priority over a coincident tick: the state
  // moves and the amplitude is held for that cycle.
  always_comb begin
    for (int unsigned i = 0; i < NVOICE; i++) begin
      state_n[i] = state[i];
      amp_n[i]   = amp[i];
      case (state[i])
        IDLE: begin
          amp_n[i] = '0;
          if (gate_s[i]) begin
            state_n[i] = ATTACK;
          end
        end
        ATTACK: begin
          if (!gate_s[i]) begin
            state_n[i] = RELEASE;
          end else if (tick) begin
            amp_n[i] = attack_step(amp[i]);
            if (amp_n[i] == 8'd255) begin
              state_n[i] = SUSTAIN;
            end
          end
        end
        SUSTAIN: begin
          if (!gate_s[i]) begin
            state_n[i] = RELEASE;
          end
        end
        RELEASE: begin
          // Retrigger resumes the attack from the current amplitude.
          if (gate_s[i]) begin
            state_n[i] = ATTACK;
          end else if (tick) begin
            amp_n[i] = release_step(amp[i]);
            if (amp_n[i] == 8'd0) begin
              state_n[i] = IDLE;
            end
          end
        end
        default: begin
          state_n[i] = IDLE;
          amp_n[i]   = '0;
        end
      endcase
    end
  end

  always_comb begin
    env_active = '0;
    for (int unsigned i = 0; i < NVOICE; i++) begin
      env_active[i] = (state[i] != IDLE);
    end
  end

  // ---------------------------------------------------------------------------
  // Mixer
  // ---------------------------------------------------------------------------
  logic [9:0] mix;

  always_comb begin
    mix = '0;
    for (int unsigned i = 0; i < NVOICE; i++) begin
      if (voice_in[i]) begin
        mix = mix + 10'(amp[i]);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level <= '0;
    end else begin
      level <= mix;
    end
  end

  // ---------------------------------------------------------------------------
  // PWM
  // ---------------------------------------------------------------------------
  // level is captured only at the frame boundary so a mid-frame change never
  // produces a partial-duty frame.
  logic [9:0] pwm_cnt;
  logic [9:0] lvl_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pwm_cnt <= '0;
      lvl_q   <= '0;
      pwm_out <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + 10'd1;
      if (pwm_cnt == 10'd1023) begin
        lvl_q <= level;
      end
      pwm_out <= (pwm_cnt < lvl_q);
    end
  end

endmodule

// File: tb/tb_noise_env_mixer.sv
// Self-checking bench for noise_env_mixer.
//   A cycle-level behavioural model (integer arithmetic) runs in lockstep and
//   is compared against level, env_active and pwm_out every cycle. Directed
//   sequences check the envelope step values, retrigger, mix table, PWM duty
//   and asynchronous reset against hand-derived constants.
//   Define NOISE_MIX_EXP_RELEASE_EN for both files to check the exponential
//   release build.
`timescale 1ns/1ps
module tb_noise_env_mixer;

  localparam int RATE_DIV = 4;
  localparam int ATK_STEP = 64;
  localparam int REL_STEP = 32;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] gate;
  logic [3:0] voice_in;
  logic       pwm_out;
  logic [9:0] level;
  logic [3:0] env_active;

  noise_env_mixer #(
    .NVOICE  (4),
    .RATE_DIV(RATE_DIV),
    .ATK_STEP(ATK_STEP),
    .REL_STEP(REL_STEP)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .gate      (gate),
    .voice_in  (voice_in),
    .pwm_out   (pwm_out),
    .level     (level),
    .env_active(env_active)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural reference model
  // ---------------------------------------------------------------------------
  typedef enum {PH_IDLE, PH_ATTACK, PH_SUSTAIN, PH_RELEASE} phase_e;

  phase_e m_ph  [4];
  int     m_amp [4];
  int     m_g1  [4];
  int     m_gs  [4];
  int     m_presc, m_level, m_cnt, m_lvlq, m_pwm;

  function automatic int release_amount(input int a);
`ifdef NOISE_MIX_EXP_RELEASE_EN
    return (a / 8 > 0) ? a / 8 : 1;
`else
    return REL_STEP;
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_ph[i]  = PH_IDLE;
      m_amp[i] = 0;
      m_g1[i]  = 0;
      m_gs[i]  = 0;
    end
    m_presc = 0;
    m_level = 0;
    m_cnt   = 0;
    m_lvlq  = 0;
    m_pwm   = 0;
  endtask

  // Advance the model by one clock edge using the inputs seen at that edge.
  task automatic model_edge(input logic [3:0] g, input logic [3:0] v);
    bit tick;
    int sum;
    bit on;
    tick = (m_presc == RATE_DIV - 1);
    sum  = 0;
    for (int i = 0; i < 4; i++) if (v[i]) sum += m_amp[i];
    m_pwm = (m_cnt < m_lvlq) ? 1 : 0;
    if (m_cnt == 1023) m_lvlq = m_level;
    m_cnt   = (m_cnt + 1) % 1024;
    m_level = sum;
    for (int i = 0; i < 4; i++) begin
      on = (m_gs[i] != 0);
      case (m_ph[i])
        PH_IDLE:    if (on) m_ph[i] = PH_ATTACK;
        PH_ATTACK: begin
          if (!on) m_ph[i] = PH_RELEASE;
          else if (tick) begin
            m_amp[i] = (m_amp[i] + ATK_STEP > 255) ? 255 : m_amp[i] + ATK_STEP;
            if (m_amp[i] == 255) m_ph[i] = PH_SUSTAIN;
          end
        end
        PH_SUSTAIN: if (!on) m_ph[i] = PH_RELEASE;
        PH_RELEASE: begin
          if (on) m_ph[i] = PH_ATTACK;
          else if (tick) begin
            m_amp[i] = m_amp[i] - release_amount(m_amp[i]);
            if (m_amp[i] < 0) m_amp[i] = 0;
            if (m_amp[i] == 0) m_ph[i] = PH_IDLE;
          end
        end
        default: m_ph[i] = PH_IDLE;
      endcase
      m_gs[i] = m_g1[i];
      m_g1[i] = g[i];
    end
    m_presc = (m_presc + 1) % RATE_DIV;
  endtask

  function automatic logic [3:0] model_env();
    logic [3:0] e;
    for (int i = 0; i < 4; i++) e[i] = (m_ph[i] != PH_IDLE);
    return e;
  endfunction

  // One clock cycle: update the model at the edge, compare 1 ns later.
  task automatic cycle();
    logic [3:0] g;
    logic [3:0] v;
    g = gate;
    v = voice_in;
    @(posedge clk);
    if (reset) model_reset();
    else       model_edge(g, v);
    #1;
    check("level", int'(level), m_level);
    check("env_active", int'(env_active), int'(model_env()));
    check("pwm_out", int'(pwm_out), m_pwm);
  endtask

  task automatic next_change(input string name, input int exp, input int budget);
    int prev;
    int n;
    prev = int'(level);
    n    = 0;
    while (int'(level) == prev && n < budget) begin
      cycle();
      n++;
    end
    if (int'(level) == prev) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: level stuck at %0d for %0d cycles, expected %0d", name, prev, budget, exp);
    end else begin
      check(name, int'(level), exp);
    end
  endtask

  task automatic wait_level(input string name, input int target, input int budget);
    int n;
    n = 0;
    while (int'(level) != target && n < budget) begin
      cycle();
      n++;
    end
    check(name, int'(level), target);
  endtask

  task automatic wait_cnt(input int c);
    int n;
    n = 0;
    while (m_cnt != c && n < 2048) begin
      cycle();
      n++;
    end
  endtask

  task automatic pwm_frame(input string name, input int exp);
    int highs;
    wait_cnt(1);
    highs = 0;
    repeat (1024) begin
      cycle();
      highs += int'(pwm_out);
    end
    check(name, highs, exp);
  endtask

  // ---------------------------------------------------------------------------
  // Directed data
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [3:0] vin;
    int         exp_level;
    logic [3:0] exp_env;
  } mix_vec_t;

  mix_vec_t mix_tab [6];
  int attack_seq [4] = '{64, 128, 192, 255};
`ifdef NOISE_MIX_EXP_RELEASE_EN
  int release_seq [3] = '{224, 196, 172};
  localparam int RT_LEVEL = 172;
`else
  int release_seq [8] = '{223, 191, 159, 127, 95, 63, 31, 0};
  localparam int RT_LEVEL = 127;
`endif

  initial begin
    int highs;

    mix_tab[0] = '{4'b1111, 1020, 4'b1111};
    mix_tab[1] = '{4'b0101,  510, 4'b1111};
    mix_tab[2] = '{4'b0000,    0, 4'b1111};
    mix_tab[3] = '{4'b1000,  255, 4'b1111};
    mix_tab[4] = '{4'b0011,  510, 4'b1111};
    mix_tab[5] = '{4'b1110,  765, 4'b1111};

    // Reset state
    reset    = 1'b1;
    gate     = '0;
    voice_in = '0;
    model_reset();
    repeat (3) cycle();
    check("reset level", int'(level), 0);
    check("reset env_active", int'(env_active), 0);
    check("reset pwm_out", int'(pwm_out), 0);
    reset = 1'b0;
    repeat (2) cycle();

    // Attack: env_active rises 3 cycles after the gate edge
    gate     = 4'b0001;
    voice_in = 4'b0001;
    cycle();
    cycle();
    check("env_active at 2 cycles", int'(env_active[0]), 0);
    cycle();
    check("env_active at 3 cycles", int'(env_active[0]), 1);
    foreach (attack_seq[i]) next_change("attack step", attack_seq[i], 64);
    repeat (20) cycle();
    check("sustain hold", int'(level), 255);

    // Release
    gate = '0;
    foreach (release_seq[i]) next_change("release step", release_seq[i], 64);
`ifdef NOISE_MIX_EXP_RELEASE_EN
    wait_level("exp release reaches 0", 0, 600);
`endif
    cycle();
    check("release idle env_active", int'(env_active[0]), 0);

    // Retrigger from the middle of a release
    gate = 4'b0001;
    wait_level("re-attack to 255", 255, 200);
    gate = '0;
    wait_level("release to retrigger point", RT_LEVEL, 200);
    gate = 4'b0001;
    next_change("retrigger step 1", RT_LEVEL + ATK_STEP, 64);
    next_change("retrigger step 2", 255, 64);
    check("retrigger env_active", int'(env_active[0]), 1);

    // Mix table with all voices sustained
    gate     = 4'b1111;
    voice_in = '0;
    repeat (60) cycle();
    foreach (mix_tab[i]) begin
      voice_in = mix_tab[i].vin;
      cycle();
      check("mix level", int'(level), mix_tab[i].exp_level);
      check("mix env_active", int'(env_active), int'(mix_tab[i].exp_env));
    end

    // PWM duty
    voice_in = 4'b0000;
    repeat (1100) cycle();
    pwm_frame("pwm duty level 0", 0);
    voice_in = 4'b1111;
    repeat (1100) cycle();
    pwm_frame("pwm duty level 1020", 1020);
    voice_in = 4'b0001;
    repeat (1100) cycle();
    pwm_frame("pwm duty level 255", 255);
    // Mid-frame change: the rest of this frame keeps the old duty
    wait_cnt(300);
    voice_in = 4'b0011;
    highs = 0;
    do begin
      cycle();
      highs += int'(pwm_out);
    end while (m_cnt != 0);
    check("pwm old duty completes", highs, 0);
    highs = 0;
    repeat (1024) begin
      cycle();
      highs += int'(pwm_out);
    end
    check("pwm new duty next frame", highs, 510);

    // Asynchronous reset mid-attack
    gate     = '0;
    voice_in = '0;
    repeat (200) cycle();
    gate     = 4'b0001;
    voice_in = 4'b0001;
    wait_level("mid attack", 128, 64);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check("async reset level", int'(level), 0);
    check("async reset env_active", int'(env_active), 0);
    check("async reset pwm_out", int'(pwm_out), 0);
    cycle();
    cycle();
    reset = 1'b0;
    cycle();
    cycle();
    check("restart env_active at 2 cycles", int'(env_active[0]), 0);
    cycle();
    check("restart env_active at 3 cycles", int'(env_active[0]), 1);
    next_change("restart first attack step", 64, 64);

    // Randomised gates and noise bits against the model
    gate     = '0;
    voice_in = '0;
    repeat (3000) begin
      for (int b = 0; b < 4; b++) if ($urandom_range(63) == 0) gate[b] = ~gate[b];
      voice_in = 4'($urandom);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, %0d failures so far", n_fail);
    $fatal(1);
  end

endmodule
